prog_seq_generator: RTL and testbench

- Parametrised successor to the team's fixed 3-bit T-flip-flop random-sequence generator (7,4,1,6,2,5,…).
- Plays back a run-time programmable sequence of up to DEPTH WIDTH-bit values held in an internal table.
- Adds enable, direction, one-shot/cyclic modes, run-time length and table rewrite.
- Reset defaults reproduce the legacy 7,4,1,6,2,5 sequence, so it drops in wherever the old generator fed a sequence detector or test stimulus.

---
 rtl/seq_gen_pkg.sv | 22 ++
 rtl/seq_table.sv | 41 ++++
 rtl/prog_seq_generator.sv | 115 +++++++++++
 tb/tb_prog_seq_generator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared constants and helpers for the programmable sequence generator.
// LEGACY_SEQ packs the legacy 7,4,1,6,2,5 sequence. Entry i sits at [i*3 +: 3],
// so the first value played (7) is in the low bits.
package seq_gen_pkg;

    localparam int unsigned LEGACY_LEN = 6;

    localparam logic [17:0] LEGACY_SEQ = {3'd5, 3'd2, 3'd6, 3'd1, 3'd4, 3'd7};

    // Forces a requested active length into the legal range 1..depth.
    function automatic int unsigned clamp_len(input int unsigned len_in,
                                              input int unsigned depth);
        if (len_in == 0) begin
            return 1;
        end else if (len_in > depth) begin
            return depth;
        end else begin
            return len_in;
        end
    endfunction

endpackage

// File: rtl/seq_table.sv
// Sequence value table: a DEPTH x WIDTH register file.
// Writes are synchronous. Reads are asynchronous. Reset reloads DEFAULT_SEQ.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset; reloads every entry
//   wr_en    write strobe
//   wr_addr  write address; addresses >= DEPTH are dropped
//   wr_data  write data
//   rd_addr  read address
//   rd_data  combinational read data
module seq_table #(
    parameter int unsigned            WIDTH       = 3,
    parameter int unsigned            DEPTH       = 8,
    parameter logic [DEPTH*WIDTH-1:0] DEFAULT_SEQ = '0,
    localparam int unsigned           AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= DEFAULT_SEQ[i*WIDTH +: WIDTH];
            end
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            // The range guard matters only when DEPTH is not a power of two.
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_seq_generator.sv
// Programmable sequence generator.
// Plays back up to DEPTH table entries, forward or reverse.
// Runs cyclic or one-shot over a run-time active length.
// Reset defaults reproduce the legacy 7,4,1,6,2,5 generator.
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   en        advance one step per cycle
//   rev       0 = forward, 1 = reverse
//   one_shot  0 = cyclic, 1 = stop at sequence end
//   restart   idx <- 0, done <- 0
//   wr_en     table write strobe
//   wr_addr   table write address
//   wr_data   table write data
//   len_wr    load a new active length (clamped to 1..DEPTH)
//   len_in    requested length
//   qout      table[idx], combinational
//   idx       current index, registered
//   at_end    current index is the last one in the present direction
//   wrap      one-cycle pulse the cycle after the index wraps
//   done      one-shot run finished
module prog_seq_generator
    import seq_gen_pkg::*;
#(
    parameter int unsigned            WIDTH       = 3,
    parameter int unsigned            DEPTH       = 8,
    parameter int unsigned            DEFAULT_LEN = LEGACY_LEN,
    parameter logic [DEPTH*WIDTH-1:0] DEFAULT_SEQ = (DEPTH*WIDTH)'(LEGACY_SEQ),
    localparam int unsigned           AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rev,
    input  logic             one_shot,
    input  logic             restart,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             len_wr,
    input  logic [AW:0]      len_in,
    output logic [WIDTH-1:0] qout,
    output logic [AW-1:0]    idx,
    output logic             at_end,
    output logic             wrap,
    output logic             done
);

    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic          done_q, done_d;
    logic          wrap_q, wrap_d;
    logic [AW:0]   last_idx;

    seq_table #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .DEFAULT_SEQ (DEFAULT_SEQ)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_q),
        .rd_data (qout)
    );

    // len_q is never 0, so last_idx always fits in AW bits.
    assign last_idx = len_q - (AW+1)'(1);
    assign at_end   = (!rev && ({1'b0, idx_q} == last_idx)) || (rev && (idx_q == '0));

    always_comb begin
        idx_d  = idx_q;
        len_d  = len_q;
        done_d = done_q;
        wrap_d = 1'b0;
        if (len_wr) begin
            len_d  = (AW+1)'(clamp_len(32'(len_in), DEPTH));
            idx_d  = '0;
            done_d = 1'b0;
        end else if (restart) begin
            idx_d  = '0;
            done_d = 1'b0;
        end else if (en && !done_q) begin
            if (!at_end) begin
                idx_d = rev ? idx_q - AW'(1) : idx_q + AW'(1);
            end else if (!one_shot) begin
                idx_d  = rev ? AW'(last_idx) : '0;
                wrap_d = 1'b1;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            len_q  <= (AW+1)'(DEFAULT_LEN);
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            len_q  <= len_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
        end
    end

    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_prog_seq_generator.sv
module tb_prog_seq_generator;

    localparam int WIDTH = 3;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst, en, rev, one_shot, restart, wr_en, len_wr;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW:0]      len_in;
    logic [WIDTH-1:0] qout;
    logic [AW-1:0]    idx;
    logic             at_end, wrap, done;

    always #5 clk = ~clk;

    prog_seq_generator #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rev      (rev),
        .one_shot (one_shot),
        .restart  (restart),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .len_wr   (len_wr),
        .len_in   (len_in),
        .qout     (qout),
        .idx      (idx),
        .at_end   (at_end),
        .wrap     (wrap),
        .done     (done)
    );

    // Reference model state
    int mtab [DEPTH];
    int midx, mlen, mdone, mwrap;
    int legacy [DEPTH] = '{7, 4, 1, 6, 2, 5, 0, 0};

    typedef struct {
        string tag;
        int    q;
        int    i;
        int    w;
        int    d;
    } exp_t;
    exp_t sb [$];

    int errors = 0;
    int checks = 0;

    // Literal expectations taken straight from the intended behaviour
    int fwd_q   [7] = '{4, 1, 6, 2, 5, 7, 4};
    int fwd_w   [7] = '{0, 0, 0, 0, 0, 1, 0};
    int os_q    [8] = '{4, 1, 6, 2, 5, 5, 5, 5};
    int os_d    [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    int rev_q   [6] = '{5, 2, 6, 1, 4, 7};
    int rev_w   [6] = '{1, 0, 0, 0, 0, 0};
    int len8_q  [8] = '{4, 1, 6, 2, 5, 0, 0, 7};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int m_at_end();
        return int'((rev == 1'b0 && midx == mlen - 1) || (rev == 1'b1 && midx == 0));
    endfunction

    task automatic idle();
        rst = 0; en = 0; rev = 0; one_shot = 0; restart = 0;
        wr_en = 0; wr_addr = '0; wr_data = '0; len_wr = 0; len_in = '0;
    endtask

    // Apply the currently driven inputs for one clock and score the result.
    task automatic tick(input string tag);
        exp_t e;
        int   ae;
        ae = m_at_end();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mtab[i] = legacy[i];
            midx = 0; mlen = 6; mdone = 0; mwrap = 0;
        end else begin
            if (wr_en && int'(wr_addr) < DEPTH) mtab[wr_addr] = int'(wr_data);
            mwrap = 0;
            if (len_wr) begin
                mlen  = (len_in == 0) ? 1 : ((int'(len_in) > DEPTH) ? DEPTH : int'(len_in));
                midx  = 0;
                mdone = 0;
            end else if (restart) begin
                midx  = 0;
                mdone = 0;
            end else if (en && mdone == 0) begin
                if (ae == 0) begin
                    midx = rev ? midx - 1 : midx + 1;
                end else if (!one_shot) begin
                    midx  = rev ? mlen - 1 : 0;
                    mwrap = 1;
                end else begin
                    mdone = 1;
                end
            end
        end
        e = '{tag, mtab[midx], midx, mwrap, mdone};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".qout"}, 32'(qout), e.q);
        check({e.tag, ".idx"}, 32'(idx), e.i);
        check({e.tag, ".wrap"}, 32'(wrap), e.w);
        check({e.tag, ".done"}, 32'(done), e.d);
        check({e.tag, ".at_end"}, 32'(at_end), m_at_end());
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick("reset");
        rst = 0;
    endtask

    initial begin
        idle();

        // Reset state: legacy first value, not at end
        do_reset();
        check("reset_qout7", 32'(qout), 7);
        check("reset_at_end0", 32'(at_end), 0);

        // Forward cyclic
        en = 1;
        for (int k = 0; k < 7; k++) begin
            tick("fwd");
            check("fwd_lit_q", 32'(qout), fwd_q[k]);
            check("fwd_lit_w", 32'(wrap), fwd_w[k]);
            check("fwd_lit_done", 32'(done), 0);
        end

        // One-shot, then restart
        do_reset();
        en = 1; one_shot = 1;
        for (int k = 0; k < 8; k++) begin
            tick("oneshot");
            check("os_lit_q", 32'(qout), os_q[k]);
            check("os_lit_d", 32'(done), os_d[k]);
        end
        // done holds after one_shot is cleared, and idx stays put
        one_shot = 0;
        tick("done_hold");
        check("done_hold_lit", 32'(done), 1);
        restart = 1;
        tick("restart");
        check("restart_lit_q", 32'(qout), 7);
        check("restart_lit_d", 32'(done), 0);
        restart = 0;

        // Reverse cyclic from reset
        do_reset();
        en = 1; rev = 1;
        for (int k = 0; k < 6; k++) begin
            tick("rev");
            check("rev_lit_q", 32'(qout), rev_q[k]);
            check("rev_lit_w", 32'(wrap), rev_w[k]);
        end

        // Direction change mid-run: at idx 0, at_end follows rev combinationally
        rev = 0; en = 0;
        #1;
        check("dir_at_end_fwd", 32'(at_end), 0);
        rev = 1;
        #1;
        check("dir_at_end_rev", 32'(at_end), 1);
        rev = 0;
        tick("dir_idle");

        // len_in = 0 clamps to 1
        len_wr = 1; len_in = 0;
        tick("len0");
        len_wr = 0; en = 1;
        for (int k = 0; k < 3; k++) begin
            tick("len1_run");
            check("len1_lit_q", 32'(qout), 7);
            check("len1_lit_w", 32'(wrap), 1);
        end
        // len_in = 15 clamps to 8
        en = 0; len_wr = 1; len_in = 15;
        tick("len15");
        len_wr = 0; en = 1;
        for (int k = 0; k < 8; k++) begin
            tick("len8_run");
            check("len8_lit_q", 32'(qout), len8_q[k]);
        end

        // Write into the entry being stepped to
        do_reset();
        en = 1;
        tick("pre_wr");
        tick("pre_wr");
        check("pre_wr_idx2", 32'(idx), 2);
        wr_en = 1; wr_addr = 3; wr_data = 3;
        tick("wr_step");
        check("wr_step_lit_q", 32'(qout), 3);
        wr_en = 0;

        // Write entry 0, make it visible, then reset restores it
        en = 0; wr_en = 1; wr_addr = 0; wr_data = 2; restart = 1;
        tick("wr0");
        check("wr0_lit_q", 32'(qout), 2);
        wr_en = 0; restart = 0; en = 1;
        tick("run");
        do_reset();
        check("rst_mid_lit_q", 32'(qout), 7);
        check("rst_mid_lit_idx", 32'(idx), 0);

        // len_wr + restart + en together: len_wr wins
        en = 1;
        tick("pre_pri");
        tick("pre_pri");
        len_wr = 1; len_in = 3; restart = 1;
        tick("pri");
        check("pri_lit_idx", 32'(idx), 0);
        len_wr = 0; restart = 0;
        tick("len3");
        tick("len3");
        tick("len3");
        check("len3_lit_q", 32'(qout), 7);
        check("len3_lit_w", 32'(wrap), 1);

        // en low: idx holds and wrap clears
        en = 0;
        tick("en_low");
        check("en_low_lit_w", 32'(wrap), 0);

        if (sb.size() != 0) begin
            check("sb_empty", 32'(sb.size()), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
